ring_johnson_cnt: RTL and testbench
===================================

RING_JOHNSON_CNT -- requirements
Module: ring_johnson_cnt

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 SHALL derive local parameter IDXW = $clog2(2*WIDTH), the width of the position index.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port en, input, 1, shift enable.
REQ-006 SHALL have port dir, input, 1, shift direction: 0 = toward MSB, 1 = toward LSB.
REQ-007 SHALL have port mode, input, 1, counter mode: 0 = ring (one-hot), 1 = Johnson (twisted ring).
REQ-008 SHALL have port load, input, 1, synchronous load strobe.
REQ-009 SHALL have port load_val, input, WIDTH, the value to load.
REQ-010 SHALL have port out, output, WIDTH, the registered counter state.
REQ-011 SHALL have port idx, output, IDXW, the sequence position decoded from out.
REQ-012 SHALL have port wrap, output, 1, registered one-cycle sequence-wrap pulse.
REQ-013 SHALL have port err, output, 1, registered one-cycle illegal-load pulse.

Function
REQ-014 SHALL keep an internal mode_q register; the active mode is always mode_q.
REQ-015 SHALL define the seed as 0...01 for ring and 0...0 for Johnson.
REQ-016 SHALL apply this per-edge priority, highest first:
- mode != mode_q: mode_q <= mode, out <= seed of the new mode, no shift.
- load: legal load_val -> out <= load_val; illegal -> out <= seed and err = 1.
- en: shift one step.
- otherwise: hold.
REQ-017 SHALL shift in ring mode as follows:
- dir=0: out <= {out[W-2:0], out[W-1]}.
- dir=1: out <= {out[0], out[W-1:1]}.
REQ-018 SHALL shift in Johnson mode as follows:
- dir=0: out <= {out[W-2:0], ~out[W-1]}.
- dir=1: out <= {~out[0], out[W-1:1]}.
REQ-019 SHALL treat a value as a legal ring load only when it has exactly one bit set.
REQ-020 SHALL treat a value as a legal Johnson load only when it is one of the 2*WIDTH states reachable from 0...0 by dir=0 shifts.
REQ-021 SHALL decode idx combinationally from out and mode_q:
- ring: idx = index of the set bit (0..W-1).
- Johnson: idx = popcount(out) if out[W-1]=0, else 2W - popcount(out) (0..2W-1).
REQ-022 SHALL assert wrap for exactly the cycle following an en-shift that moves idx from last to 0 (dir=0) or from 0 to last (dir=1); last = W-1 for ring, 2W-1 for Johnson.
REQ-023 SHALL never assert wrap on a load or a mode reinit.
REQ-024 SHALL deassert err and wrap on every edge where their set condition is absent.
REQ-025 SHALL let dir change on any cycle, taking effect on the next shift with no bubble.
REQ-026 SHALL ignore en and load on any edge where a mode reinit occurs; err stays 0 on that edge.

Reset
REQ-027 SHALL, while rst=0 and asynchronously, force out = 0...01, mode_q = 0, wrap = 0, err = 0; idx therefore reads 0.
REQ-028 SHALL, when mode=1 at the first rising edge after rst deasserts, perform a mode reinit to 0...0 on that edge.
REQ-029 SHALL, on reset asserted mid-shift or mid-load, discard the pending update and take reset values immediately.

Verification (WIDTH=4)
REQ-030 SHALL cover ring up: reset, mode=0, en=1, dir=0 for 5 clocks -> out 0010,0100,1000,0001,0010; wrap high only in the cycle out=0001.
REQ-031 SHALL cover Johnson down: mode=1, en=1, dir=1 from 0000 -> out 1000,1100,1110,1111,0111; idx 7,6,5,4,3; wrap high only in the cycle out=1000.
REQ-032 SHALL cover load legality:
- ring, load_val=0100 -> out=0100, idx=2, err=0.
- ring, load_val=0110 -> out=0001, err=1 for one cycle.
- Johnson, load_val=0101 -> out=0000, err=1.
REQ-033 SHALL cover the simultaneous event: mode toggles 0->1 with load=1 and en=1 on the same edge -> out=0000, err=0, wrap=0; next en edge (dir=0) -> out=0001.
REQ-034 SHALL cover async reset: rst pulled low between edges while out=1000 -> out=0001 and wrap=err=0 before the next edge; counting resumes from 0001 after release.
REQ-035 SHALL cover hold and direction change: en=0 for 3 clocks -> out unchanged; then dir alternating 0/1 each clock with en=1 -> out oscillates between two adjacent states.

Source files
------------

// File: rtl/ring_johnson_cnt.sv
// ring_johnson_cnt: bidirectional ring / Johnson counter with checked
// synchronous load, combinational position decode, and registered
// one-cycle wrap and illegal-load pulses.
module ring_johnson_cnt #(
    parameter int WIDTH = 4,
    localparam int IDXW = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic [IDXW-1:0]  idx,
    output logic             wrap,
    output logic             err
);

    typedef enum logic {
        MODE_RING    = 1'b0,
        MODE_JOHNSON = 1'b1
    } mode_e;

    localparam logic [WIDTH-1:0] RING_SEED    = WIDTH'(1);
    localparam logic [WIDTH-1:0] JOHNSON_SEED = '0;

    mode_e            mode_q;
    mode_e            mode_in;
    mode_e            mode_d;
    logic [WIDTH-1:0] out_d;
    logic             wrap_d;
    logic             err_d;
    logic [IDXW-1:0]  last_idx;

    // Starting state of each mode's sequence (position 0).
    function automatic logic [WIDTH-1:0] seed_of(input mode_e m);
        return (m == MODE_JOHNSON) ? JOHNSON_SEED : RING_SEED;
    endfunction

    // One shift step; the fed-back bit is inverted in Johnson mode.
    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] v,
                                                    input logic d,
                                                    input mode_e m);
        logic fb;
        if (!d) begin
            fb = (m == MODE_JOHNSON) ? ~v[WIDTH-1] : v[WIDTH-1];
            return {v[WIDTH-2:0], fb};
        end
        fb = (m == MODE_JOHNSON) ? ~v[0] : v[0];
        return {fb, v[WIDTH-1:1]};
    endfunction

    // Ring states are exactly the one-hot values.
    function automatic logic ring_legal(input logic [WIDTH-1:0] v);
        return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    endfunction

    // Johnson states are a run of ones anchored at bit 0 (0...0 up to
    // 1...1) or a run of ones anchored at the MSB (1...10 down to 10...0).
    // A value is a low-anchored run exactly when v & (v+1) is zero; the
    // high-anchored case is the same test applied to ~v.
    function automatic logic johnson_legal(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] nv;
        nv = ~v;
        return ((v & (v + WIDTH'(1))) == '0) || ((nv & (nv + WIDTH'(1))) == '0);
    endfunction

    function automatic logic load_legal(input logic [WIDTH-1:0] v, input mode_e m);
        return (m == MODE_JOHNSON) ? johnson_legal(v) : ring_legal(v);
    endfunction

    assign mode_in  = mode_e'(mode);
    assign last_idx = (mode_q == MODE_JOHNSON) ? IDXW'(2 * WIDTH - 1) : IDXW'(WIDTH - 1);

    // Position decode: set-bit index for ring, ones-count folded about the
    // MSB for Johnson.
    // NOTE: every always_comb output gets a default before any branch so no
    // path leaves it unassigned; a missing default would infer a latch.
    always_comb begin
        int pc;
        idx = '0;
        pc  = 0;
        if (mode_q == MODE_RING) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (out[i]) begin
                    idx = IDXW'(i);
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                pc = pc + int'(out[i]);
            end
            if (!out[WIDTH-1]) begin
                idx = IDXW'(pc);
            end else begin
                idx = IDXW'(2 * WIDTH - pc);
            end
        end
    end

    // Next-state selection: mode reinit beats load beats shift beats hold.
    // Wrap and err default low so they only ever pulse for one cycle.
    always_comb begin
        mode_d = mode_q;
        out_d  = out;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (mode_in != mode_q) begin
            mode_d = mode_in;
            out_d  = seed_of(mode_in);
        end else if (load) begin
            if (load_legal(load_val, mode_q)) begin
                out_d = load_val;
            end else begin
                out_d = seed_of(mode_q);
                err_d = 1'b1;
            end
        end else if (en) begin
            out_d  = shift_step(out, dir, mode_q);
            wrap_d = dir ? (idx == '0) : (idx == last_idx);
        end
    end

    // State register; reset forces the ring seed immediately.
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement or process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= MODE_RING;
            out    <= RING_SEED;
            wrap   <= 1'b0;
            err    <= 1'b0;
        end else begin
            mode_q <= mode_d;
            out    <= out_d;
            wrap   <= wrap_d;
            err    <= err_d;
        end
    end

endmodule

// File: tb/tb_ring_johnson_cnt.sv
// Self-checking bench for ring_johnson_cnt (WIDTH=4): directed vector table,
// hand-written reset/hold/direction sequences, and randomized stimulus
// compared against a position-based reference model.
module tb_ring_johnson_cnt;

    localparam int W  = 4;
    localparam int IW = $clog2(2 * W);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          dir = 1'b0;
    logic          mode = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [W-1:0]  out;
    logic [IW-1:0] idx;
    logic          wrap;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the counter is a position on a cycle of length
    // W (ring) or 2W (Johnson); out is derived from the position.
    logic m_mode;
    int   m_pos;
    logic m_wrap;
    logic m_err;

    typedef struct {
        logic         en;
        logic         dir;
        logic         mode;
        logic         load;
        logic [W-1:0] lv;
        logic [W-1:0] out;
        int           idx;
        logic         wrap;
        logic         err;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ring_johnson_cnt #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .out      (out),
        .idx      (idx),
        .wrap     (wrap),
        .err      (err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int period(input logic m);
        return m ? 2 * W : W;
    endfunction

    // Counter value at position p of the given mode's sequence.
    function automatic logic [W-1:0] gen_out(input logic m, input int p);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) begin
            if (!m)        v[i] = (i == p);
            else if (p <= W) v[i] = (i < p);
            else           v[i] = (i >= p - W);
        end
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 1'b0;
        m_pos  = 0;
        m_wrap = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_step();
        int n;
        int hit;
        m_wrap = 1'b0;
        m_err  = 1'b0;
        if (mode != m_mode) begin
            m_mode = mode;
            m_pos  = 0;
        end else if (load) begin
            hit = -1;
            for (int p = 0; p < period(m_mode); p++) begin
                if (gen_out(m_mode, p) == load_val) hit = p;
            end
            if (hit >= 0) begin
                m_pos = hit;
            end else begin
                m_pos = 0;
                m_err = 1'b1;
            end
        end else if (en) begin
            n = period(m_mode);
            if (!dir) begin
                m_wrap = (m_pos == n - 1);
                m_pos  = (m_pos + 1) % n;
            end else begin
                m_wrap = (m_pos == 0);
                m_pos  = (m_pos + n - 1) % n;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out"},  out,  gen_out(m_mode, m_pos));
        check({tag, ".idx"},  idx,  m_pos);
        check({tag, ".wrap"}, wrap, m_wrap);
        check({tag, ".err"},  err,  m_err);
    endtask

    task automatic set_in(input logic e, input logic d, input logic m,
                          input logic l, input logic [W-1:0] lv);
        en = e; dir = d; mode = m; load = l; load_val = lv;
    endtask

    initial begin
        // Directed table, applied back to back from the reset state.
        //            en dir mode load lv       out      idx wrap err
        vecs.push_back('{1, 0, 0, 0, 4'b0000, 4'b0010, 1, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 4'b0000, 4'b0100, 2, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 4'b0000, 4'b1000, 3, 0, 0});
        vecs.push_back('{1, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 0});
        vecs.push_back('{1, 0, 0, 0, 4'b0000, 4'b0010, 1, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 4'b0000, 4'b1000, 7, 1, 0});
        vecs.push_back('{1, 1, 1, 0, 4'b0000, 4'b1100, 6, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 4'b0000, 4'b1110, 5, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 4'b0000, 4'b1111, 4, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 4'b0000, 4'b0111, 3, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 4'b0100, 4'b0100, 2, 0, 0});
        vecs.push_back('{0, 0, 0, 1, 4'b0110, 4'b0001, 0, 0, 1});
        vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 4'b0101, 4'b0000, 0, 0, 1});
        vecs.push_back('{0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0});
        vecs.push_back('{1, 0, 1, 1, 4'b0100, 4'b0000, 0, 0, 0});
        vecs.push_back('{1, 0, 1, 0, 4'b0000, 4'b0001, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 4'b1100, 4'b1100, 6, 0, 0});
        vecs.push_back('{0, 0, 1, 1, 4'b1000, 4'b1000, 7, 0, 0});
        vecs.push_back('{1, 0, 1, 0, 4'b0000, 4'b0000, 0, 1, 0});
        vecs.push_back('{1, 0, 1, 0, 4'b0000, 4'b0001, 1, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0});
        vecs.push_back('{1, 1, 0, 0, 4'b0000, 4'b1000, 3, 1, 0});

        // Reset state, held from time zero.
        model_reset();
        @(negedge clk);
        check("reset.out",  out,  4'b0001);
        check("reset.idx",  idx,  0);
        check("reset.wrap", wrap, 1'b0);
        check("reset.err",  err,  1'b0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            set_in(vecs[i].en, vecs[i].dir, vecs[i].mode, vecs[i].load, vecs[i].lv);
            tick();
            check($sformatf("vec%0d.out", i),  out,  vecs[i].out);
            check($sformatf("vec%0d.idx", i),  idx,  vecs[i].idx);
            check($sformatf("vec%0d.wrap", i), wrap, vecs[i].wrap);
            check($sformatf("vec%0d.err", i),  err,  vecs[i].err);
        end

        // Async reset between edges while out=1000 with a shift pending;
        // wrap is high from the last vector, so reset must clear it.
        set_in(1, 0, 0, 0, '0);
        #2 rst = 1'b0;
        #1;
        check("async_rst.out",  out,  4'b0001);
        check("async_rst.idx",  idx,  0);
        check("async_rst.wrap", wrap, 1'b0);
        check("async_rst.err",  err,  1'b0);
        model_reset();
        #1 rst = 1'b1;
        tick();
        check("async_rst.resume", out, 4'b0010);
        check_model("async_rst.resume");

        // Hold for three clocks, then alternate direction every clock.
        set_in(0, 0, 0, 0, '0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("hold%0d.out", k),  out,  4'b0010);
            check($sformatf("hold%0d.wrap", k), wrap, 1'b0);
        end
        for (int k = 0; k < 6; k++) begin
            set_in(1, k[0], 0, 0, '0);
            tick();
            check($sformatf("osc%0d.out", k), out, (k % 2 == 0) ? 4'b0100 : 4'b0010);
            check_model($sformatf("osc%0d", k));
        end

        // mode=1 while reset releases: first edge reinitialises to Johnson.
        rst = 1'b0;
        set_in(1, 0, 1, 0, '0);
        #1;
        model_reset();
        check("rst_mode1.held", out, 4'b0001);
        #1 rst = 1'b1;
        tick();
        check("rst_mode1.out", out, 4'b0000);
        check("rst_mode1.idx", idx, 0);
        check_model("rst_mode1");
        tick();
        check("rst_mode1.shift", out, 4'b0001);
        check_model("rst_mode1.shift");

        // Randomized stimulus against the model, with occasional
        // mid-cycle resets.
        for (int c = 0; c < 400; c++) begin
            en  = ($urandom_range(0, 9) < 7);
            dir = $urandom_range(0, 1);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            load = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 1) == 0)
                load_val = gen_out(m_mode, $urandom_range(0, period(m_mode) - 1));
            else
                load_val = W'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check_model($sformatf("rnd%0d.rst", c));
                #1 rst = 1'b1;
            end
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
